rx_controller: RTL and testbench

- Back end for the UART receive front end; sits between it and the Wishbone register file.
- Decodes each completed raw frame against the control-register configuration: data extraction, parity check, stop-bit check and break detection.
- Buffers decoded characters in a small FIFO and maintains sticky status flags, a receive idle-timeout and the receive interrupt.

---
 rtl/rx_controller.sv | 276 +++++++++++++++++++++++++++
 tb/tb_rx_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_controller.sv
// rx_controller
// -------------
// Receive back end for the UART. Takes completed raw frames from the receive
// front end and decodes them against the current control-register settings:
// data extraction, parity check, stop-bit check and break detection. Decoded
// characters go into a small FIFO. The block also keeps sticky status flags,
// runs an idle timeout and drives a registered interrupt.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   cr_clk_div_i   clock cycles per bit period (0 behaves as 1)
//   cr_ds_i        data size: 0 = 7 bits, 1 = 8 bits
//   cr_p_i         parity: 00 none, 01 even, 10/11 odd
//   cr_s_i         stop bits: 0 = one, 1 = two
//   frame_i        raw frame, LSB = first data bit, right-aligned
//   frame_valid_i  one-cycle pulse qualifying frame_i
//   pop_i          read strobe for the FIFO head
//   rd_data_o      head entry {fe, pe, data[7:0]}, 0 when empty
//   rxne_o         FIFO not empty
//   rxfull_o       FIFO full
//   sr_o           sticky flags {tmo, brk, fe, pe, ore}
//   sr_clr_i       write-one-to-clear, same bit order as sr_o
//   ie_rxne_i      interrupt enable, data available
//   ie_err_i       interrupt enable, any sticky flag
//   irq_o          registered interrupt
module rx_controller #(
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] cr_clk_div_i,
    input  logic        cr_ds_i,
    input  logic [1:0]  cr_p_i,
    input  logic        cr_s_i,
    input  logic [10:0] frame_i,
    input  logic        frame_valid_i,
    input  logic        pop_i,
    output logic [9:0]  rd_data_o,
    output logic        rxne_o,
    output logic        rxfull_o,
    output logic [4:0]  sr_o,
    input  logic [4:0]  sr_clr_i,
    input  logic        ie_rxne_i,
    input  logic        ie_err_i,
    output logic        irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(TIMEOUT_BITS + 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(TIMEOUT_BITS - 1);
    localparam logic [BW-1:0] ALL_BITS = BW'(TIMEOUT_BITS);

    // Sticky flag bit positions
    localparam int SR_ORE = 0;
    localparam int SR_PE  = 1;
    localparam int SR_FE  = 2;
    localparam int SR_BRK = 3;
    localparam int SR_TMO = 4;

    // ------------------------------------------------------------------
    // Frame decode (combinational, uses cr_* of the frame_valid_i cycle)
    // ------------------------------------------------------------------
    logic [3:0]  n_bits;
    logic        par_en;
    logic        par_bit;
    logic [3:0]  stop_pos;
    logic        stop1;
    logic        stop2;
    logic [3:0]  pkt_size;
    logic [7:0]  dec_data;
    logic        dec_pe;
    logic        dec_fe;
    logic        dec_brk;
    logic [10:0] in_pkt;

    always_comb begin
        n_bits   = cr_ds_i ? 4'd8 : 4'd7;
        par_en   = |cr_p_i;
        // Bit 7 is parity or stop in 7-bit mode, so it is masked out of data.
        dec_data = {cr_ds_i & frame_i[7], frame_i[6:0]};
        par_bit  = frame_i[n_bits];
        // Stop bits sit right after the parity bit, or after the data bits.
        stop_pos = n_bits + {3'b000, par_en};
        stop1    = frame_i[stop_pos];
        stop2    = frame_i[stop_pos + 4'd1];
        pkt_size = stop_pos + 4'd1 + {3'b000, cr_s_i};
        dec_fe   = ~stop1 | (cr_s_i & ~stop2);
        // Even parity expects an even total count of ones, odd expects odd.
        dec_pe   = par_en & ((^dec_data ^ par_bit) != (cr_p_i != 2'b01));
        dec_brk  = ~|(frame_i & in_pkt);
    end

    // Mask of frame bits belonging to the configured packet
    genvar gi;
    generate
        for (gi = 0; gi < 11; gi++) begin : g_pkt_mask
            assign in_pkt[gi] = (4'(gi) < pkt_size);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] head_reg, head_next;
    logic [AW-1:0] tail_reg, tail_next;
    logic [AW:0]   count_reg, count_next;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push_req;
    logic          do_push;
    logic          do_pop;
    logic          drop;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == FULL_CNT);
    assign push_req   = frame_valid_i & ~dec_brk;
    assign do_pop     = pop_i & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a push while full still fits.
    assign do_push    = push_req & (~fifo_full | do_pop);
    assign drop       = push_req & fifo_full & ~do_pop;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (do_push) begin
            tail_next = tail_reg + 1'b1;
        end
        if (do_pop) begin
            head_next = head_reg + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Storage carries no reset; the output is masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[tail_reg] <= {dec_fe, dec_pe, dec_data};
        end
    end

    assign rxne_o    = ~fifo_empty;
    assign rxfull_o  = fifo_full;
    assign rd_data_o = fifo_empty ? 10'd0 : mem[head_reg];

    // ------------------------------------------------------------------
    // Idle timeout
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        EXPIRED = 2'd2
    } tmo_state_t;

    tmo_state_t    state_reg, state_next;
    logic [15:0]   cyc_reg, cyc_next;
    logic [BW-1:0] bit_reg, bit_next;
    logic [15:0]   div_last;
    logic          tmo_set;

    assign div_last = (cr_clk_div_i == 16'd0) ? 16'd0 : (cr_clk_div_i - 16'd1);

    always_comb begin
        state_next = state_reg;
        cyc_next   = cyc_reg;
        bit_next   = bit_reg;
        tmo_set    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = COUNT;
                    cyc_next   = '0;
                    bit_next   = '0;
                end
            end
            COUNT: begin
                if (fifo_empty) begin
                    state_next = IDLE;
                end else if (frame_valid_i || pop_i) begin
                    // Line or host activity restarts the silence window.
                    cyc_next = '0;
                    bit_next = '0;
                end else if (cyc_reg >= div_last) begin
                    cyc_next = '0;
                    if (bit_reg == LAST_BIT) begin
                        bit_next   = ALL_BITS;
                        tmo_set    = 1'b1;
                        state_next = EXPIRED;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end else begin
                    cyc_next = cyc_reg + 16'd1;
                end
            end
            EXPIRED: begin
                if (fifo_empty) begin
                    state_next = IDLE;
                end else if (frame_valid_i) begin
                    state_next = COUNT;
                    cyc_next   = '0;
                    bit_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cyc_next   = '0;
                bit_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            cyc_reg   <= '0;
            bit_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cyc_reg   <= cyc_next;
            bit_reg   <= bit_next;
        end
    end

    // ------------------------------------------------------------------
    // Sticky status and interrupt
    // ------------------------------------------------------------------
    logic [4:0] sr_reg, sr_next;
    logic [4:0] sr_set;
    logic       irq_reg;

    always_comb begin
        sr_set         = '0;
        sr_set[SR_ORE] = drop;
        sr_set[SR_PE]  = do_push & dec_pe;
        sr_set[SR_FE]  = (do_push & dec_fe) | (frame_valid_i & dec_brk);
        sr_set[SR_BRK] = frame_valid_i & dec_brk;
        sr_set[SR_TMO] = tmo_set;
        // Set has priority over a simultaneous clear.
        sr_next        = (sr_reg & ~sr_clr_i) | sr_set;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_reg  <= '0;
            irq_reg <= 1'b0;
        end else begin
            sr_reg  <= sr_next;
            irq_reg <= (ie_rxne_i & ~fifo_empty) | (ie_err_i & |sr_reg);
        end
    end

    assign sr_o  = sr_reg;
    assign irq_o = irq_reg;

endmodule

// File: tb/tb_rx_controller.sv
// Directed testbench for rx_controller: decode formats, FIFO boundaries,
// sticky flags, break, idle timeout and asynchronous reset.
module tb_rx_controller;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] cr_clk_div_i = 16'd10;
    logic        cr_ds_i = 1'b1;
    logic [1:0]  cr_p_i = 2'b00;
    logic        cr_s_i = 1'b0;
    logic [10:0] frame_i = '0;
    logic        frame_valid_i = 1'b0;
    logic        pop_i = 1'b0;
    logic [9:0]  rd_data_o;
    logic        rxne_o;
    logic        rxfull_o;
    logic [4:0]  sr_o;
    logic [4:0]  sr_clr_i = '0;
    logic        ie_rxne_i = 1'b0;
    logic        ie_err_i = 1'b0;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    rx_controller #(.FIFO_DEPTH(4), .TIMEOUT_BITS(40)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .cr_clk_div_i  (cr_clk_div_i),
        .cr_ds_i       (cr_ds_i),
        .cr_p_i        (cr_p_i),
        .cr_s_i        (cr_s_i),
        .frame_i       (frame_i),
        .frame_valid_i (frame_valid_i),
        .pop_i         (pop_i),
        .rd_data_o     (rd_data_o),
        .rxne_o        (rxne_o),
        .rxfull_o      (rxfull_o),
        .sr_o          (sr_o),
        .sr_clr_i      (sr_clr_i),
        .ie_rxne_i     (ie_rxne_i),
        .ie_err_i      (ie_err_i),
        .irq_o         (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h required %0h", tag, obs, exp);
    endtask

    // One clock, then settle just past the edge before sampling.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [10:0] f, input logic p);
        frame_i       = f;
        frame_valid_i = 1'b1;
        pop_i         = p;
        cyc();
        frame_valid_i = 1'b0;
        pop_i         = 1'b0;
    endtask

    task automatic pop1();
        pop_i = 1'b1;
        cyc();
        pop_i = 1'b0;
    endtask

    task automatic clr(input logic [4:0] m);
        sr_clr_i = m;
        cyc();
        sr_clr_i = '0;
    endtask

    initial begin
        // Reset state, observed while reset is held
        #1;
        chk("rst_rxne", 16'(rxne_o), 16'h0);
        chk("rst_full", 16'(rxfull_o), 16'h0);
        chk("rst_sr", 16'(sr_o), 16'h0);
        chk("rst_irq", 16'(irq_o), 16'h0);
        chk("rst_rdata", 16'(rd_data_o), 16'h0);
        repeat (3) cyc();
        rst_ni = 1'b1;
        cyc();

        // 8N1 basic receive
        send(11'h1A5, 1'b0);
        chk("8n1_rxne", 16'(rxne_o), 16'h1);
        chk("8n1_data", 16'(rd_data_o), 16'h0A5);
        pop1();
        chk("8n1_pop", 16'(rxne_o), 16'h0);
        // Pop while empty is ignored
        pop1();
        chk("emp_pop_rxne", 16'(rxne_o), 16'h0);
        chk("emp_pop_sr", 16'(sr_o), 16'h0);
        // Push and pop together while empty: push wins
        send(11'h1A5, 1'b1);
        chk("emp_pp_rxne", 16'(rxne_o), 16'h1);
        chk("emp_pp_data", 16'(rd_data_o), 16'h0A5);
        pop1();
        chk("emp_pp_pop", 16'(rxne_o), 16'h0);

        // 7E2: 0x41 has two ones, so correct even parity bit is 0
        cr_ds_i = 1'b0;
        cr_p_i  = 2'b01;
        cr_s_i  = 1'b1;
        send(11'h341, 1'b0);
        chk("7e2_ok_data", 16'(rd_data_o), 16'h041);
        chk("7e2_ok_sr", 16'(sr_o), 16'h00);
        send(11'h3C1, 1'b0);
        chk("7e2_bad_sr", 16'(sr_o), 16'h02);
        pop1();
        chk("7e2_bad_data", 16'(rd_data_o), 16'h141);
        clr(5'b00010);
        chk("7e2_clr_sr", 16'(sr_o), 16'h00);
        pop1();
        chk("7e2_empty", 16'(rxne_o), 16'h0);

        // Full boundary in 8N1
        cr_ds_i = 1'b1;
        cr_p_i  = 2'b00;
        cr_s_i  = 1'b0;
        for (int i = 1; i <= 4; i++) send(11'h100 | 11'(i), 1'b0);
        chk("full_flag", 16'(rxfull_o), 16'h1);
        chk("full_sr", 16'(sr_o), 16'h00);
        send(11'h105, 1'b0);
        chk("ovr_sr", 16'(sr_o), 16'h01);
        chk("ovr_full", 16'(rxfull_o), 16'h1);
        send(11'h106, 1'b1);
        chk("fpp_full", 16'(rxfull_o), 16'h1);
        chk("fpp_head", 16'(rd_data_o), 16'h002);
        pop1();
        chk("drain_3", 16'(rd_data_o), 16'h003);
        pop1();
        chk("drain_4", 16'(rd_data_o), 16'h004);
        pop1();
        chk("drain_6", 16'(rd_data_o), 16'h006);
        pop1();
        chk("drain_empty", 16'(rxne_o), 16'h0);
        clr(5'b00001);
        chk("ovr_clr", 16'(sr_o), 16'h00);

        // Break frame: no push, brk and fe set, irq one cycle later
        ie_err_i = 1'b1;
        send(11'h000, 1'b0);
        chk("brk_rxne", 16'(rxne_o), 16'h0);
        chk("brk_sr", 16'(sr_o), 16'h0C);
        chk("brk_irq_lag", 16'(irq_o), 16'h0);
        cyc();
        chk("brk_irq", 16'(irq_o), 16'h1);
        clr(5'b01100);
        ie_err_i = 1'b0;
        cyc();
        chk("brk_clr_sr", 16'(sr_o), 16'h00);
        chk("brk_clr_irq", 16'(irq_o), 16'h0);

        // Timeout: 10 cycles/bit x 40 bits, one entry buffered
        cr_clk_div_i = 16'd10;
        send(11'h1AA, 1'b0);
        repeat (398) cyc();
        chk("tmo_early", 16'(sr_o[4]), 16'h0);
        repeat (4) cyc();
        chk("tmo_set", 16'(sr_o[4]), 16'h1);
        pop1();
        clr(5'b10000);
        chk("tmo_clr", 16'(sr_o), 16'h00);

        // Timeout restart by a pop about 200 cycles in
        send(11'h111, 1'b0);
        send(11'h122, 1'b0);
        repeat (199) cyc();
        pop1();
        repeat (398) cyc();
        chk("tmo_rst_early", 16'(sr_o[4]), 16'h0);
        repeat (4) cyc();
        chk("tmo_rst_set", 16'(sr_o[4]), 16'h1);
        chk("tmo_rst_head", 16'(rd_data_o), 16'h022);
        pop1();
        clr(5'b10000);

        // Asynchronous reset mid-timeout with three entries buffered
        ie_rxne_i = 1'b1;
        for (int i = 0; i < 3; i++) send(11'h130 | 11'(i), 1'b0);
        repeat (50) cyc();
        chk("pre_rst_irq", 16'(irq_o), 16'h1);
        chk("pre_rst_rxne", 16'(rxne_o), 16'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_rxne", 16'(rxne_o), 16'h0);
        chk("arst_sr", 16'(sr_o), 16'h00);
        chk("arst_irq", 16'(irq_o), 16'h0);
        chk("arst_rdata", 16'(rd_data_o), 16'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
